// File: rtl/seg_scan_driver.sv
// Time-multiplexed N-digit seven-segment scanner with per-frame snapshot, blanking, dp and guard time.
// Latency: outputs registered one cycle after cnt/idx; no backpressure (free-running while enable=1, frozen when low).
// Optional leading-zero suppression at snapshot time when SEG_SCAN_LZ_BLANK_EN is defined.
module seg_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 2,
  parameter bit HEX_MODE    = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  output logic [7:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    frame_start
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic                    first_frame;
  logic [4*NUM_DIGITS-1:0] shadow_dig;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic [NUM_DIGITS-1:0]   shadow_blank;

  logic                    slot_end;
  logic                    wrap;
  logic                    snap;
  logic [NUM_DIGITS-1:0]   blank_snap;
  logic [3:0]              cur_code;
  logic                    cur_dp;
  logic                    cur_blank;
  logic                    guard_ok;
  logic [7:0]              seg_nxt;
  logic [NUM_DIGITS-1:0]   an_nxt;

  function automatic logic [6:0] decode(input logic [3:0] code);
    logic [6:0] s;
    case (code)
      4'h0: s = 7'b1111110;
      4'h1: s = 7'b0110000;
      4'h2: s = 7'b1101101;
      4'h3: s = 7'b1111001;
      4'h4: s = 7'b0110011;
      4'h5: s = 7'b1011011;
      4'h6: s = 7'b1011111;
      4'h7: s = 7'b1110000;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1111011;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b0011111;
      4'hC: s = 7'b1001110;
      4'hD: s = 7'b0111101;
      4'hE: s = 7'b1001111;
      default: s = 7'b1000111;
    endcase
    return s;
  endfunction

  assign slot_end = (cnt == CW'(REFRESH_DIV - 1));
  assign wrap     = slot_end && (idx == IW'(NUM_DIGITS - 1));
  assign snap     = enable && (first_frame || wrap);

`ifdef SEG_SCAN_LZ_BLANK_EN
  logic lz_run;
  always_comb begin
    blank_snap = blank_in;
    lz_run     = 1'b1;
    // Digit 0 is excluded so an all-zero value still shows a single 0.
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (lz_run && (digits_in[4*i +: 4] == 4'd0) && !dp_in[i]) begin
        blank_snap[i] = 1'b1;
      end else begin
        lz_run = 1'b0;
      end
    end
  end
`else
  assign blank_snap = blank_in;
`endif

  // During the very first enabled cycle the shadow is still empty, so read the
  // value being captured; later wraps must not bypass, or the last slot would tear.
  always_comb begin
    cur_code  = 4'd0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    if (first_frame) begin
      cur_code  = digits_in[4*int'(idx) +: 4];
      cur_dp    = dp_in[idx];
      cur_blank = blank_snap[idx];
    end else begin
      cur_code  = shadow_dig[4*int'(idx) +: 4];
      cur_dp    = shadow_dp[idx];
      cur_blank = shadow_blank[idx];
    end
  end

  always_comb begin
    guard_ok = (int'(cnt) >= GUARD);
    seg_nxt  = {cur_dp, decode(cur_code)};
    an_nxt   = '0;
    if (!enable || cur_blank || (!HEX_MODE && (cur_code > 4'd9))) begin
      seg_nxt = 8'd0;
    end
    if (enable && guard_ok) begin
      an_nxt = NUM_DIGITS'(1) << idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      idx          <= '0;
      first_frame  <= 1'b1;
      shadow_dig   <= '0;
      shadow_dp    <= '0;
      shadow_blank <= '0;
      seg_out      <= 8'd0;
      an_out       <= '0;
      frame_start  <= 1'b0;
    end else begin
      seg_out     <= seg_nxt;
      an_out      <= an_nxt;
      frame_start <= snap;
      if (enable) begin
        first_frame <= 1'b0;
        if (slot_end) begin
          cnt <= '0;
          idx <= wrap ? '0 : idx + 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
      if (snap) begin
        shadow_dig   <= digits_in;
        shadow_dp    <= dp_in;
        shadow_blank <= blank_snap;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: 4-digit hex, 4-digit decimal-only and 1-digit/no-guard instances.
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] digits = 16'h1234;
  logic [3:0]  dp = 4'd0;
  logic [3:0]  blank = 4'd0;

  logic [7:0]  seg, seg_h0, seg_1;
  logic [3:0]  an, an_h0;
  logic [0:0]  an_1;
  logic        fs, fs_h0, fs_1;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  seg_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .GUARD(1), .HEX_MODE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .digits_in(digits), .dp_in(dp),
    .blank_in(blank), .seg_out(seg), .an_out(an), .frame_start(fs));

  seg_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .GUARD(1), .HEX_MODE(1'b0)) dut_h0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .digits_in(digits), .dp_in(dp),
    .blank_in(blank), .seg_out(seg_h0), .an_out(an_h0), .frame_start(fs_h0));

  seg_scan_driver #(.NUM_DIGITS(1), .REFRESH_DIV(3), .GUARD(0), .HEX_MODE(1'b1)) dut_n1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .digits_in(digits[3:0]), .dp_in(dp[0]),
    .blank_in(blank[0]), .seg_out(seg_1), .an_out(an_1), .frame_start(fs_1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Returns at the first falling edge where the given digit is lit.
  task automatic wait_slot(input int d, input string tag, output logic [7:0] s);
    bit found = 1'b0;
    logic [3:0] want;
    want = 4'b0001 << d;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      if (an == want) found = 1'b1;
    end
    if (!found) check({tag, "_timeout"}, {28'd0, an}, {28'd0, want});
    s = seg;
  endtask

  task automatic wait_fs(input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      if (fs) found = 1'b1;
    end
    if (!found) check({tag, "_timeout"}, {31'd0, fs}, 32'd1);
  endtask

  logic [7:0] s;
  logic [3:0] an_exp [8] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h2};
  int fs_cnt, an1_bad, seg1_bad;

  initial begin
    repeat (2) @(negedge clk);
    check("rst_seg", seg, 8'h00);
    check("rst_an", an, 4'h0);
    check("rst_fs", fs, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("dis_an", an, 4'h0);
    check("dis_fs", fs, 1'b0);
    enable = 1'b1;

    // first frame: guard then three lit cycles per slot
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("seq_an%0d", i), an, an_exp[i]);
      if (i == 0) check("first_fs", fs, 1'b1);
      if (i == 1) check("seq_seg_d0", seg, 8'h33);
      if (i == 5) check("seq_seg_d1", seg, 8'h79);
    end

    // inputs change mid-frame; rest of frame keeps old snapshot
    digits = 16'h5678;
    wait_slot(2, "tear_d2", s); check("tear_d2", s, 8'h6D);
    wait_slot(3, "tear_d3", s); check("tear_d3", s, 8'h30);
    wait_fs("tear_fs");
    wait_slot(0, "new_d0", s); check("new_d0", s, 8'h7F);
    wait_slot(3, "new_d3", s); check("new_d3", s, 8'h5B);

    // hex vs decimal-only decoding
    digits = 16'hFA00;
    wait_fs("hex_fs");
    wait_slot(0, "hex_d0", s); check("hex_d0", s, 8'h7E); check("h0_d0", seg_h0, 8'h7E);
    wait_slot(2, "hex_d2", s); check("hex_d2", s, 8'h77);
    check("h0_d2_seg", seg_h0, 8'h00); check("h0_d2_an", an_h0, 4'h4);
    wait_slot(3, "hex_d3", s); check("hex_d3", s, 8'h47);
    check("h0_d3_seg", seg_h0, 8'h00); check("h0_d3_an", an_h0, 4'h8);

    // blanking and decimal points
    digits = 16'h1234; blank = 4'b0100; dp = 4'b0010;
    wait_fs("bd_fs");
    wait_slot(0, "bd_d0", s); check("bd_d0", s, 8'h33);
    wait_slot(1, "bd_d1", s); check("bd_d1", s, 8'hF9);
    wait_slot(2, "bd_d2", s); check("bd_d2", s, 8'h00);
    wait_slot(3, "bd_d3", s); check("bd_d3", s, 8'h30);

    // enable dropped in digit-2 slot, resumed from held counter
    blank = 4'd0; dp = 4'd0;
    wait_fs("en_fs");
    wait_slot(2, "en_d2", s); check("en_d2", s, 8'h6D);
    enable = 1'b0;
    @(negedge clk);
    check("en_off_an", an, 4'h0); check("en_off_seg", seg, 8'h00);
    repeat (3) @(negedge clk);
    check("en_hold_an", an, 4'h0);
    enable = 1'b1;
    @(negedge clk);
    check("en_res_an", an, 4'h4); check("en_res_seg", seg, 8'h6D); check("en_res_fs", fs, 1'b0);
    @(negedge clk);
    check("en_res_an2", an, 4'h4);
    @(negedge clk);
    check("en_res_guard", an, 4'h0); check("en_res_fs2", fs, 1'b0);

    // asynchronous reset mid-cycle
    wait_slot(1, "ar_d1", s);
    #2 rst_n = 1'b0;
    #1;
    check("ar_an", an, 4'h0); check("ar_seg", seg, 8'h00); check("ar_seg1", seg_1, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ar_first_fs", fs, 1'b1);
    check("n1_first_fs", fs_1, 1'b1);

    // single digit, no guard: always lit, snapshot every slot
    fs_cnt = 0; an1_bad = 0; seg1_bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (fs_1) fs_cnt++;
      if (an_1 !== 1'b1) an1_bad++;
      if (seg_1 !== 8'h33) seg1_bad++;
    end
    check("n1_fs_count", fs_cnt, 10);
    check("n1_an_off", an1_bad, 0);
    check("n1_seg_bad", seg1_bad, 0);

    // leading zeros
    digits = 16'h0070;
    wait_fs("lz_fs");
    wait_slot(0, "lz_d0", s); check("lz_d0", s, 8'h7E);
    wait_slot(1, "lz_d1", s); check("lz_d1", s, 8'h70);
`ifdef SEG_SCAN_LZ_BLANK_EN
    wait_slot(2, "lz_d2", s); check("lz_d2", s, 8'h00);
    wait_slot(3, "lz_d3", s); check("lz_d3", s, 8'h00);
`else
    wait_slot(2, "lz_d2", s); check("lz_d2", s, 8'h7E);
    wait_slot(3, "lz_d3", s); check("lz_d3", s, 8'h7E);
`endif
    digits = 16'h0000;
    wait_fs("lz0_fs");
    wait_slot(0, "lz0_d0", s); check("lz0_d0", s, 8'h7E);
`ifdef SEG_SCAN_LZ_BLANK_EN
    wait_slot(1, "lz0_d1", s); check("lz0_d1", s, 8'h00);
    wait_slot(3, "lz0_d3", s); check("lz0_d3", s, 8'h00);
`else
    wait_slot(1, "lz0_d1", s); check("lz0_d1", s, 8'h7E);
    wait_slot(3, "lz0_d3", s); check("lz0_d3", s, 8'h7E);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
